// File: rtl/l0_cache_read_controller_pkg.sv
// Shared types and default geometry for the L0 data cache read/lookup path.
// Also holds the per-byte merge helper used for same-cycle write bypass.
package l0_cache_read_controller_pkg;

  localparam int unsigned L0_XLEN        = 32;
  localparam int unsigned L0_INDEX_WIDTH = 7;
  localparam int unsigned L0_TAG_WIDTH   = 7;
  localparam int unsigned L0_BYTES       = L0_XLEN / 8;
  localparam logic [L0_XLEN-1:0] L0_MMIO_ADDR = 32'h4000_0000;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } l0_cache_sweep_state_e;

  typedef struct packed {
    logic [L0_TAG_WIDTH-1:0] tag;
    logic [L0_BYTES-1:0]     valid;
    logic [L0_XLEN-1:0]      data;
  } l0_cache_entry_t;

  // Written bytes win over the RAM copy, all other lanes pass through.
  function automatic logic [L0_XLEN-1:0] merge_bytes(
    input logic [L0_XLEN-1:0]  ram_data,
    input logic [L0_XLEN-1:0]  wr_data,
    input logic [L0_BYTES-1:0] wr_be
  );
    logic [L0_XLEN-1:0] res;
    res = ram_data;
    for (int b = 0; b < L0_BYTES; b++) begin
      if (wr_be[b]) begin
        res[8*b +: 8] = wr_data[8*b +: 8];
      end else begin
        res[8*b +: 8] = ram_data[8*b +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cache_invalidate_sweeper.sv
// Whole-cache invalidation sweep: walks every index once after reset or on request,
// raising busy and a write strobe for each entry.
module cache_invalidate_sweeper
  import l0_cache_read_controller_pkg::*;
#(
  parameter int unsigned IW = L0_INDEX_WIDTH
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_we,
  output logic [IW-1:0] o_index
);

  localparam logic [IW-1:0] LastIdx = '1;

  l0_cache_sweep_state_e state_q;
  logic [IW-1:0]         cnt_q;
  logic                  busy_q;

  // Sweep FSM; a start request restarts from index 0 even mid-sweep.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else if (i_start) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        SWEEP: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastIdx) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= SWEEP;
            busy_q  <= 1'b1;
          end
        end
        IDLE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy  = busy_q;
  assign o_we    = busy_q;
  assign o_index = cnt_q;

endmodule

// File: rtl/l0_cache_read_controller_chk.sv
// Protocol checks for the L0 read controller: no RAM writes while the sweep owns
// the write port, and a lookup never reports hit and miss together.
module l0_cache_read_controller_chk (
  input logic i_clk,
  input logic i_rst_n,
  input logic i_busy,
  input logic i_cache_write_enable,
  input logic i_hit,
  input logic i_miss
);

  a_no_write_in_sweep: assert property (
    @(posedge i_clk) disable iff (!i_rst_n) !(i_busy && i_cache_write_enable)
  );

  a_hit_miss_excl: assert property (
    @(posedge i_clk) disable iff (!i_rst_n) !(i_hit && i_miss)
  );

endmodule

// File: rtl/l0_cache_read_controller.sv
// L0 data cache lookup: drives the RAM read index from EX, resolves hit/miss and
// load data in MA, bypasses same-cycle writes and owns the invalidation sweep.
module l0_cache_read_controller
  import l0_cache_read_controller_pkg::*;
#(
  parameter int unsigned        XLEN            = L0_XLEN,
  parameter int unsigned        CacheIndexWidth = L0_INDEX_WIDTH,
  parameter int unsigned        CacheTagWidth   = L0_TAG_WIDTH,
  parameter logic [XLEN-1:0]    MMIO_ADDR       = L0_MMIO_ADDR
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_stall,
  input  logic                       i_flush,
  input  logic                       i_invalidate_all,
  input  logic                       i_load_valid_ex,
  input  logic [XLEN-1:0]            i_load_address_ex,
  input  logic [XLEN/8-1:0]          i_load_byte_mask_ex,
  output logic [CacheIndexWidth-1:0] o_cache_read_index,
  input  logic [XLEN-1:0]            i_cache_read_data,
  input  logic [CacheTagWidth-1:0]   i_cache_read_tag,
  input  logic [XLEN/8-1:0]          i_cache_read_valid,
  input  logic                       i_cache_write_enable,
  input  logic [CacheIndexWidth-1:0] i_cache_write_index,
  input  logic [XLEN/8-1:0]          i_cache_write_byte_enable,
  input  logic [XLEN-1:0]            i_cache_write_data,
  input  logic [CacheTagWidth-1:0]   i_cache_write_tag,
  input  logic [XLEN/8-1:0]          i_cache_write_valid,
  output logic                       o_inval_write_enable,
  output logic [CacheIndexWidth-1:0] o_inval_write_index,
  output logic                       o_busy,
  output logic                       o_hit_ma,
  output logic                       o_miss_ma,
  output logic [XLEN-1:0]            o_hit_data_ma
);

  localparam int unsigned IW = CacheIndexWidth;
  localparam int unsigned TW = CacheTagWidth;

  logic [XLEN-1:0]   addr_ma_q;
  logic [XLEN/8-1:0] mask_ma_q;
  logic              load_valid_ma_q;

  logic              bypass_valid_q;
  logic [XLEN/8-1:0] bypass_be_q;
  l0_cache_entry_t   bypass_q;

  logic [IW-1:0]     read_index_s;
  logic [TW-1:0]     tag_ma_s;
  logic [TW-1:0]     tag_eff_s;
  logic [XLEN/8-1:0] valid_eff_s;
  logic [XLEN-1:0]   data_eff_s;
  logic              mmio_ma_s;
  logic              hit_s;

  cache_invalidate_sweeper #(.IW(IW)) u_sweeper (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (i_invalidate_all),
    .o_busy  (o_busy),
    .o_we    (o_inval_write_enable),
    .o_index (o_inval_write_index)
  );

  // A stalled MA re-reads its own index so the RAM output tracks any writes.
  assign read_index_s       = i_stall ? addr_ma_q[2 +: IW] : i_load_address_ex[2 +: IW];
  assign o_cache_read_index = read_index_s;

  // MA pipeline registers; flush beats the stall hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_ma_q       <= '0;
      mask_ma_q       <= '0;
      load_valid_ma_q <= 1'b0;
    end else begin
      if (!i_stall) begin
        addr_ma_q <= i_load_address_ex;
        mask_ma_q <= i_load_byte_mask_ex;
      end else begin
        addr_ma_q <= addr_ma_q;
        mask_ma_q <= mask_ma_q;
      end
      if (i_flush) begin
        load_valid_ma_q <= 1'b0;
      end else if (!i_stall) begin
        load_valid_ma_q <= i_load_valid_ex;
      end else begin
        load_valid_ma_q <= load_valid_ma_q;
      end
    end
  end

  // Snoop the write port against the index being read this cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bypass_valid_q <= 1'b0;
      bypass_be_q    <= '0;
      bypass_q       <= '0;
    end else begin
      bypass_valid_q <= i_cache_write_enable && (i_cache_write_index == read_index_s);
      bypass_be_q    <= i_cache_write_byte_enable;
      bypass_q.tag   <= i_cache_write_tag;
      bypass_q.valid <= i_cache_write_valid;
      bypass_q.data  <= i_cache_write_data;
    end
  end

  // Effective entry seen by MA: RAM output patched with the bypassed write.
  always_comb begin
    tag_eff_s   = i_cache_read_tag;
    valid_eff_s = i_cache_read_valid;
    data_eff_s  = i_cache_read_data;
    if (bypass_valid_q) begin
      tag_eff_s   = bypass_q.tag;
      valid_eff_s = bypass_q.valid;
      data_eff_s  = merge_bytes(i_cache_read_data, bypass_q.data, bypass_be_q);
    end else begin
      tag_eff_s   = i_cache_read_tag;
      valid_eff_s = i_cache_read_valid;
      data_eff_s  = i_cache_read_data;
    end
  end

  assign tag_ma_s  = addr_ma_q[(2+IW) +: TW];
  assign mmio_ma_s = (addr_ma_q >= MMIO_ADDR);
  assign hit_s     = load_valid_ma_q && !mmio_ma_s && !o_busy &&
                     (tag_eff_s == tag_ma_s) && !(|(mask_ma_q & ~valid_eff_s));

  assign o_hit_ma      = hit_s;
  assign o_miss_ma     = load_valid_ma_q && !o_busy && !hit_s;
  assign o_hit_data_ma = data_eff_s;

  l0_cache_read_controller_chk u_chk (
    .i_clk                (i_clk),
    .i_rst_n              (i_rst_n),
    .i_busy               (o_busy),
    .i_cache_write_enable (i_cache_write_enable),
    .i_hit                (o_hit_ma),
    .i_miss               (o_miss_ma)
  );

endmodule

// File: tb/tb_l0_cache_read_controller.sv
// Self-checking bench for l0_cache_read_controller: table-driven lookups through a
// scoreboard queue, plus hand sequences for sweep, stall, flush and restart.
module tb_l0_cache_read_controller;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_stall;
  logic        i_flush;
  logic        i_invalidate_all;
  logic        i_load_valid_ex;
  logic [31:0] i_load_address_ex;
  logic [3:0]  i_load_byte_mask_ex;
  logic [6:0]  o_cache_read_index;
  logic [31:0] i_cache_read_data;
  logic [6:0]  i_cache_read_tag;
  logic [3:0]  i_cache_read_valid;
  logic        i_cache_write_enable;
  logic [6:0]  i_cache_write_index;
  logic [3:0]  i_cache_write_byte_enable;
  logic [31:0] i_cache_write_data;
  logic [6:0]  i_cache_write_tag;
  logic [3:0]  i_cache_write_valid;
  logic        o_inval_write_enable;
  logic [6:0]  o_inval_write_index;
  logic        o_busy;
  logic        o_hit_ma;
  logic        o_miss_ma;
  logic [31:0] o_hit_data_ma;

  always #5 i_clk = ~i_clk;

  l0_cache_read_controller dut (
    .i_clk                     (i_clk),
    .i_rst_n                   (i_rst_n),
    .i_stall                   (i_stall),
    .i_flush                   (i_flush),
    .i_invalidate_all          (i_invalidate_all),
    .i_load_valid_ex           (i_load_valid_ex),
    .i_load_address_ex         (i_load_address_ex),
    .i_load_byte_mask_ex       (i_load_byte_mask_ex),
    .o_cache_read_index        (o_cache_read_index),
    .i_cache_read_data         (i_cache_read_data),
    .i_cache_read_tag          (i_cache_read_tag),
    .i_cache_read_valid        (i_cache_read_valid),
    .i_cache_write_enable      (i_cache_write_enable),
    .i_cache_write_index       (i_cache_write_index),
    .i_cache_write_byte_enable (i_cache_write_byte_enable),
    .i_cache_write_data        (i_cache_write_data),
    .i_cache_write_tag         (i_cache_write_tag),
    .i_cache_write_valid       (i_cache_write_valid),
    .o_inval_write_enable      (o_inval_write_enable),
    .o_inval_write_index       (o_inval_write_index),
    .o_busy                    (o_busy),
    .o_hit_ma                  (o_hit_ma),
    .o_miss_ma                 (o_miss_ma),
    .o_hit_data_ma             (o_hit_data_ma)
  );

  typedef struct {
    logic        lv;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [6:0]  rtag;
    logic [3:0]  rvalid;
    logic [31:0] rdata;
    logic        we;
    logic [6:0]  widx;
    logic [3:0]  wbe;
    logic [31:0] wdata;
    logic [6:0]  wtag;
    logic [3:0]  wvalid;
    logic        ehit;
    logic        emiss;
    logic [31:0] edata;
  } vec_t;

  typedef struct {
    int          id;
    logic        hit;
    logic        miss;
    logic [31:0] data;
  } exp_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];
  exp_t sb_q [$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic pulse_invalidate();
    i_invalidate_all = 1'b1;
    @(posedge i_clk);
    #1 i_invalidate_all = 1'b0;
    @(negedge i_clk);
  endtask

  // Starting at a negedge where the sweep shows index 0, follow all 128 writes.
  task automatic sweep_check(input string nm);
    for (int k = 0; k < 128; k++) begin
      chk(nm, {53'd0, o_busy, o_inval_write_enable, o_hit_ma, o_miss_ma, o_inval_write_index},
              {53'd0, 1'b1, 1'b1, 1'b0, 1'b0, 7'(k)});
      @(negedge i_clk);
    end
    chk({nm, "_end"}, {62'd0, o_busy, o_inval_write_enable}, 64'd0);
  endtask

  task automatic apply_vec(input int id);
    vec_t v;
    exp_t e;
    v = vecs[id];
    i_load_valid_ex           = v.lv;
    i_load_address_ex         = v.addr;
    i_load_byte_mask_ex       = v.mask;
    i_cache_write_enable      = v.we;
    i_cache_write_index       = v.widx;
    i_cache_write_byte_enable = v.wbe;
    i_cache_write_data        = v.wdata;
    i_cache_write_tag         = v.wtag;
    i_cache_write_valid       = v.wvalid;
    #1 chk("read_index", {57'd0, o_cache_read_index}, {57'd0, v.addr[8:2]});
    sb_q.push_back('{id, v.ehit, v.emiss, v.ehit ? v.edata : 32'd0});
    @(posedge i_clk);
    #1;
    i_load_valid_ex      = 1'b0;
    i_cache_write_enable = 1'b0;
    i_cache_read_tag     = v.rtag;
    i_cache_read_valid   = v.rvalid;
    i_cache_read_data    = v.rdata;
    @(negedge i_clk);
    e = sb_q.pop_front();
    if (e.id != id) $display("FAIL scoreboard order: got id %0d expected %0d", e.id, id);
    chk($sformatf("vec%0d", e.id),
        {30'd0, o_hit_ma, o_miss_ma, e.hit ? o_hit_data_ma : 32'd0},
        {30'd0, e.hit, e.miss, e.data});
  endtask

  initial begin
    //           lv    addr          mask  rtag   rvalid rdata          we    widx   wbe   wdata          wtag   wvalid hit   miss  data
    vecs[0]  = '{1'b1, 32'h0000_0104, 4'hF, 7'h00, 4'hF, 32'hDEAD_BEEF, 1'b0, 7'h00, 4'h0, 32'h0000_0000, 7'h00, 4'h0, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b1, 32'h0000_0104, 4'hC, 7'h00, 4'h3, 32'hDEAD_BEEF, 1'b0, 7'h00, 4'h0, 32'h0000_0000, 7'h00, 4'h0, 1'b0, 1'b1, 32'h0000_0000};
    vecs[2]  = '{1'b1, 32'h0000_0104, 4'hF, 7'h00, 4'h0, 32'h1122_3344, 1'b1, 7'h41, 4'h1, 32'h0000_00AA, 7'h00, 4'hF, 1'b1, 1'b0, 32'h1122_33AA};
    vecs[3]  = '{1'b1, 32'h4000_0000, 4'hF, 7'h00, 4'hF, 32'h0000_0001, 1'b0, 7'h00, 4'h0, 32'h0000_0000, 7'h00, 4'h0, 1'b0, 1'b1, 32'h0000_0000};
    vecs[4]  = '{1'b1, 32'h0000_0304, 4'hF, 7'h00, 4'hF, 32'h0000_0002, 1'b0, 7'h00, 4'h0, 32'h0000_0000, 7'h00, 4'h0, 1'b0, 1'b1, 32'h0000_0000};
    vecs[5]  = '{1'b1, 32'h0000_0104, 4'hF, 7'h00, 4'hF, 32'h1234_5678, 1'b1, 7'h42, 4'hF, 32'h5555_5555, 7'h00, 4'hF, 1'b1, 1'b0, 32'h1234_5678};
    vecs[6]  = '{1'b1, 32'h0000_0104, 4'hF, 7'h00, 4'hF, 32'h1234_5678, 1'b1, 7'h41, 4'hF, 32'h0000_0000, 7'h05, 4'hF, 1'b0, 1'b1, 32'h0000_0000};
    vecs[7]  = '{1'b1, 32'h0000_0104, 4'h3, 7'h00, 4'h3, 32'hCAFE_F00D, 1'b0, 7'h00, 4'h0, 32'h0000_0000, 7'h00, 4'h0, 1'b1, 1'b0, 32'hCAFE_F00D};
    vecs[8]  = '{1'b1, 32'h3FFF_FFFC, 4'hF, 7'h7F, 4'hF, 32'h0BAD_C0DE, 1'b0, 7'h00, 4'h0, 32'h0000_0000, 7'h00, 4'h0, 1'b1, 1'b0, 32'h0BAD_C0DE};
    vecs[9]  = '{1'b0, 32'h0000_0104, 4'hF, 7'h00, 4'hF, 32'hDEAD_BEEF, 1'b0, 7'h00, 4'h0, 32'h0000_0000, 7'h00, 4'h0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[10] = '{1'b1, 32'h0000_0104, 4'hF, 7'h00, 4'hF, 32'hDEAD_BEEF, 1'b1, 7'h41, 4'h0, 32'h0000_0000, 7'h00, 4'h0, 1'b0, 1'b1, 32'h0000_0000};
    vecs[11] = '{1'b1, 32'h4000_0004, 4'hF, 7'h00, 4'hF, 32'h0000_0003, 1'b0, 7'h00, 4'h0, 32'h0000_0000, 7'h00, 4'h0, 1'b0, 1'b1, 32'h0000_0000};

    i_rst_n = 1'b0; i_stall = 1'b0; i_flush = 1'b0; i_invalidate_all = 1'b0;
    i_load_valid_ex = 1'b1; i_load_address_ex = 32'h0000_0104; i_load_byte_mask_ex = 4'hF;
    i_cache_read_data = 32'hDEAD_BEEF; i_cache_read_tag = 7'h00; i_cache_read_valid = 4'hF;
    i_cache_write_enable = 1'b0; i_cache_write_index = 7'h00; i_cache_write_byte_enable = 4'h0;
    i_cache_write_data = 32'h0; i_cache_write_tag = 7'h00; i_cache_write_valid = 4'h0;

    // Reset state, with a matching load held on the EX inputs.
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("reset_state", {60'd0, o_busy, o_inval_write_enable, o_hit_ma, o_miss_ma}, {60'd0, 4'b1100});
    i_rst_n = 1'b1;
    sweep_check("sweep_after_reset");
    i_load_valid_ex = 1'b0;
    @(negedge i_clk);
    chk("idle_no_lookup", {62'd0, o_hit_ma, o_miss_ma}, 64'd0);

    for (int i = 0; i < NVEC; i++) apply_vec(i);
    if (sb_q.size() != 0) chk("scoreboard_drain", 64'(sb_q.size()), 64'd0);

    // Stall: MA holds its hit and keeps re-reading its own index.
    apply_vec(0);
    i_load_valid_ex = 1'b1; i_load_address_ex = 32'h0000_0208; i_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d", c), {25'd0, o_hit_ma, o_miss_ma, o_cache_read_index, o_hit_data_ma},
                                    {25'd0, 1'b1, 1'b0, 7'h41, 32'hDEAD_BEEF});
      @(negedge i_clk);
    end
    // Flush while still stalled kills the MA lookup.
    i_flush = 1'b1;
    @(posedge i_clk);
    #1 i_flush = 1'b0; i_stall = 1'b0; i_load_valid_ex = 1'b0;
    @(negedge i_clk);
    chk("flush", {62'd0, o_hit_ma, o_miss_ma}, 64'd0);

    // Requested sweep, restarted at index 50.
    pulse_invalidate();
    for (int c = 0; c < 50; c++) @(negedge i_clk);
    chk("sweep_at_50", {56'd0, o_busy, o_inval_write_index}, {56'd0, 1'b1, 7'd50});
    pulse_invalidate();
    sweep_check("sweep_restart");

    // Async reset mid-sweep returns to index 0 at once.
    pulse_invalidate();
    for (int c = 0; c < 20; c++) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1 chk("async_reset", {56'd0, o_busy, o_inval_write_index}, {56'd0, 1'b1, 7'd0});
    @(negedge i_clk);
    i_rst_n = 1'b1;
    sweep_check("sweep_after_async_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
